// File: rtl/chain_delay_meter.sv
// chain_delay_meter: self-timed meter for one delay-chain lane. Launches alternating
// edges into the chain, counts cycles to synchronized arrival, and sums 2^AVG_LOG counts.
module chain_delay_meter #(
  parameter int CNT_W   = 16,
  parameter int AVG_LOG = 2,
  parameter int SETTLE  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     launch,
  input  logic                     sense,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         last,
  output logic [CNT_W+AVG_LOG-1:0] result
);

  localparam int ACC_W = CNT_W + AVG_LOG;
  localparam int RUN_W = AVG_LOG + 1;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int RUNS  = 1 << AVG_LOG;

  localparam logic [RUN_W-1:0] RUN_TOTAL  = RUNS[RUN_W-1:0];
  localparam logic [SET_W-1:0] SETTLE_CNT = SETTLE[SET_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MAX    = {ACC_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sense_s;
  logic             launch_q, launch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] settle_q, settle_d, settle_inc;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] last_q, last_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             matched;
  logic             abort;

  // Two-flop synchronizer for the chain output, which is asynchronous to clk.
  always_comb begin
    sync1_d = sense;
    sync2_d = sync1_q;
  end

  assign sense_s = sync2_q;

  // Next-state, datapath and registered-output logic for the measurement sequence.
  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    run_d      = run_q;
    acc_d      = acc_q;
    last_d     = last_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    abort      = 1'b0;
    matched    = (sense_s == launch_q);
    settle_inc = settle_q + SET_W'(1'b1);
    run_inc    = run_q + RUN_W'(1'b1);
    acc_sum    = acc_q + ACC_W'(cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d     = '0;
          run_d     = '0;
          cnt_d     = '0;
          settle_d  = '0;
          timeout_d = 1'b0;
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1'b1);
        if (matched) begin
          settle_d = settle_inc;
        end else begin
          settle_d = '0;
        end
        // A finished settle window takes priority over the cycle budget running out.
        if (matched && (settle_inc == SETTLE_CNT)) begin
          state_d = ST_FIRE;
        end else if (cnt_q == CNT_MAX) begin
          abort = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_FIRE: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        settle_d = '0;
        state_d  = ST_MEASURE;
      end

      ST_MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1'b1);
        if (matched) begin
          last_d = cnt_q;
          acc_d  = acc_sum;
          run_d  = run_inc;
          cnt_d  = '0;
          // Result is loaded on entry to DONE so it is valid while done is high.
          if (run_inc == RUN_TOTAL) begin
            result_d = acc_sum;
            state_d  = ST_DONE;
          end else begin
            settle_d = '0;
            state_d  = ST_SETTLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          abort = 1'b1;
        end else begin
          state_d = ST_MEASURE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      last_d    = CNT_MAX;
      result_d  = ACC_MAX;
      state_d   = ST_DONE;
    end else begin
      timeout_d = timeout_d;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      launch_q  <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      run_q     <= '0;
      acc_q     <= '0;
      last_q    <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      launch_q  <= launch_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      run_q     <= run_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign launch  = launch_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign last    = last_q;
  assign result  = result_q;

endmodule
